// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RISC-V core; outputs are registered Moore decodes.
// Optional ILLEGAL_TRAP_EN: unknown opcodes trap into an absorbing ERROR state.
module multicycle_main_fsm #(
    parameter int unsigned MEM_LAT = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       AdrSrc,
    output logic [1:0] ALUOp,
    output logic       illegal,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ERROR    = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcu;
        logic       br;
        logic       rw;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       as;
        logic [1:0] aop;
        logic       ill;
    } ctrl_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] LAT      = 4'(MEM_LAT);
    localparam logic       RST_DONE = (MEM_LAT == 0);
    localparam ctrl_t CTRL_RST = '{
        pcu: RST_DONE, br: 1'b0, rw: 1'b0, mw: 1'b0, irw: RST_DONE,
        rs: 2'b10, sa: 2'b00, sb: 2'b10, as: 1'b0, aop: 2'b00, ill: 1'b0
    };

    state_t     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       done_d;

    always_comb begin
        state_d = state_q;
        wcnt_d  = 4'd0;
        case (state_q)
            FETCH: begin
                if (wcnt_q == LAT) state_d = DECODE;
                else               wcnt_d  = wcnt_q + 4'd1;
            end
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = ERROR;
`else
                    default:      state_d = FETCH;
`endif
                endcase
            end
            MEMADR:  state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD: begin
                if (wcnt_q == LAT) state_d = MEMWB;
                else               wcnt_d  = wcnt_q + 4'd1;
            end
            EXECR, EXECI, JAL:           state_d = ALUWB;
            MEMWB, MEMWRITE, ALUWB, BEQ: state_d = FETCH;
`ifdef ILLEGAL_TRAP_EN
            ERROR:   state_d = ERROR;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Decode the outputs of the state being entered so they register alongside it.
    always_comb begin
        ctrl_d = '0;
        done_d = (wcnt_d == LAT);
        case (state_d)
            FETCH: begin
                ctrl_d.rs  = 2'b10;
                ctrl_d.sb  = 2'b10;
                ctrl_d.irw = done_d;
                ctrl_d.pcu = done_d;
            end
            DECODE: begin
                ctrl_d.sa = 2'b01;
                ctrl_d.sb = 2'b01;
            end
            MEMADR: begin
                ctrl_d.sa = 2'b10;
                ctrl_d.sb = 2'b01;
            end
            MEMREAD: ctrl_d.as = 1'b1;
            MEMWB: begin
                ctrl_d.rs = 2'b01;
                ctrl_d.rw = 1'b1;
            end
            MEMWRITE: begin
                ctrl_d.as = 1'b1;
                ctrl_d.mw = 1'b1;
            end
            EXECR: begin
                ctrl_d.sa  = 2'b10;
                ctrl_d.aop = 2'b10;
            end
            EXECI: begin
                ctrl_d.sa  = 2'b10;
                ctrl_d.sb  = 2'b01;
                ctrl_d.aop = 2'b10;
            end
            ALUWB: ctrl_d.rw = 1'b1;
            BEQ: begin
                ctrl_d.sa  = 2'b10;
                ctrl_d.aop = 2'b01;
                ctrl_d.br  = 1'b1;
            end
            JAL: begin
                ctrl_d.sa  = 2'b01;
                ctrl_d.sb  = 2'b10;
                ctrl_d.pcu = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            ERROR: ctrl_d.ill = 1'b1;
`endif
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            wcnt_q  <= 4'd0;
            ctrl_q  <= CTRL_RST;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign PCUpdate  = ctrl_q.pcu;
    assign Branch    = ctrl_q.br;
    assign RegWrite  = ctrl_q.rw;
    assign MemWrite  = ctrl_q.mw;
    assign IRWrite   = ctrl_q.irw;
    assign ResultSrc = ctrl_q.rs;
    assign ALUSrcA   = ctrl_q.sa;
    assign ALUSrcB   = ctrl_q.sb;
    assign AdrSrc    = ctrl_q.as;
    assign ALUOp     = ctrl_q.aop;
    assign illegal   = ctrl_q.ill;
    assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm at MEM_LAT 0, 2 and 3.
// Honours ILLEGAL_TRAP_EN for the illegal-opcode scenario.
module tb_multicycle_main_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n;
    logic [6:0]  op  [3];
    logic [18:0] obs [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       pcu, br, rw, mw, irw, as, ill;
        logic [1:0] rs, sa, sb, aop;
        logic [3:0] st;
        multicycle_main_fsm #(
            .MEM_LAT((g == 0) ? 0 : (g == 1) ? 2 : 3)
        ) u_dut (
            .clk      (clk),
            .reset_n  (rst_n[g]),
            .op       (op[g]),
            .PCUpdate (pcu),
            .Branch   (br),
            .RegWrite (rw),
            .MemWrite (mw),
            .IRWrite  (irw),
            .ResultSrc(rs),
            .ALUSrcA  (sa),
            .ALUSrcB  (sb),
            .AdrSrc   (as),
            .ALUOp    (aop),
            .illegal  (ill),
            .state_o  (st)
        );
        assign obs[g] = {st, pcu, br, rw, mw, irw, rs, sa, sb, as, aop, ill};
    end

    localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3;
    localparam logic [3:0] S_MWB = 4'd4, S_MW = 4'd5, S_XR = 4'd6;
    localparam logic [3:0] S_WB = 4'd8, S_BEQ = 4'd9, S_JAL = 4'd10;
    localparam logic [3:0] S_ERR = 4'd11;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011, BQ = 7'b1100011;
    localparam logic [6:0] JL = 7'b1101111, BAD = 7'b1111111;

    typedef struct packed {
        logic [18:0] v;
        logic [95:0] nm;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [18:0] pk(
        input logic [3:0] st, input logic pcu, input logic br,
        input logic rw, input logic mw, input logic irw,
        input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
        input logic as, input logic [1:0] aop, input logic ill);
        return {st, pcu, br, rw, mw, irw, rs, sa, sb, as, aop, ill};
    endfunction

    // Output table of each state, written from the control-signal list.
    function automatic logic [18:0] ref_out(input logic [3:0] st, input logic dn);
        case (st)
            4'd0:  return pk(st, dn, 0, 0, 0, dn, 2'b10, 2'b00, 2'b10, 0, 2'b00, 0);
            4'd1:  return pk(st, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0);
            4'd2:  return pk(st, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0);
            4'd3:  return pk(st, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0);
            4'd4:  return pk(st, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 0, 2'b00, 0);
            4'd5:  return pk(st, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0);
            4'd6:  return pk(st, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 0);
            4'd7:  return pk(st, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b10, 0);
            4'd8:  return pk(st, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0);
            4'd9:  return pk(st, 0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b01, 0);
            4'd10: return pk(st, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b00, 0);
            4'd11: return pk(st, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1);
            default: return pk(st, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0);
        endcase
    endfunction

    task automatic cmp(input int k, input logic [18:0] act, input exp_t e);
        n_chk++;
        if (act !== e.v) begin
            n_fail++;
            $display("FAIL %0s: dut%0d got %h want %h", e.nm, k, act, e.v);
        end
    endtask

    // Monitor: one expected entry per DUT cycle, compared away from the active edge.
    always @(negedge clk) begin
        if (q0.size() > 0) cmp(0, obs[0], q0.pop_front());
        if (q1.size() > 0) cmp(1, obs[1], q1.pop_front());
        if (q2.size() > 0) cmp(2, obs[2], q2.pop_front());
    end

    task automatic push(input int k, input logic [18:0] v, input logic [95:0] nm);
        exp_t e;
        e.v  = v;
        e.nm = nm;
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic step(input int k, input logic [6:0] o, input logic [3:0] st,
                        input logic dn, input logic [95:0] nm);
        op[k] = o;
        push(k, ref_out(st, dn), nm);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_now(input int k, input logic [18:0] w, input logic [95:0] nm);
        exp_t e;
        e.v  = w;
        e.nm = nm;
        cmp(k, obs[k], e);
    endtask

    task automatic start(input int k, input logic dn);
        rst_n[k] = 1'b0;
        #1;
        chk_now(k, ref_out(S_F, dn), "reset");
        @(posedge clk);
        #1;
        rst_n[k] = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 3'b000;
        for (int i = 0; i < 3; i++) op[i] = 7'd0;
        repeat (2) @(posedge clk);
        #1;

        // R-type, MEM_LAT=0
        start(0, 1'b1);
        step(0, RT, S_F,  1, "r_fetch");
        step(0, RT, S_D,  0, "r_dec");
        step(0, RT, S_XR, 0, "r_exec");
        step(0, RT, S_WB, 0, "r_wb");
        step(0, RT, S_F,  1, "r_fetch2");

        // lw, MEM_LAT=2
        start(1, 1'b0);
        step(1, LW, S_F,   0, "lw_f0");
        step(1, LW, S_F,   0, "lw_f1");
        step(1, LW, S_F,   1, "lw_f2");
        step(1, LW, S_D,   0, "lw_dec");
        step(1, LW, S_MA,  0, "lw_adr");
        step(1, LW, S_MR,  0, "lw_rd0");
        step(1, LW, S_MR,  0, "lw_rd1");
        step(1, LW, S_MR,  0, "lw_rd2");
        step(1, LW, S_MWB, 0, "lw_wb");
        step(1, LW, S_F,   0, "lw_next");

        // sw, beq, jal back to back, MEM_LAT=0
        start(0, 1'b1);
        step(0, SW, S_F,   1, "sw_f");
        step(0, SW, S_D,   0, "sw_dec");
        step(0, SW, S_MA,  0, "sw_adr");
        step(0, SW, S_MW,  0, "sw_wr");
        step(0, BQ, S_F,   1, "beq_f");
        step(0, BQ, S_D,   0, "beq_dec");
        step(0, BQ, S_BEQ, 0, "beq_ex");
        step(0, JL, S_F,   1, "jal_f");
        step(0, JL, S_D,   0, "jal_dec");
        step(0, JL, S_JAL, 0, "jal_ex");
        step(0, JL, S_WB,  0, "jal_wb");
        step(0, RT, S_F,   1, "post_f");

        // illegal opcode
        start(0, 1'b1);
        step(0, BAD, S_F, 1, "ill_f");
        step(0, BAD, S_D, 0, "ill_dec");
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) step(0, RT, S_ERR, 0, "ill_trap");
        rst_n[0] = 1'b0;
        #1;
        chk_now(0, ref_out(S_F, 1'b1), "trap_rst");
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        step(0, RT, S_F, 1, "trap_f");
        step(0, RT, S_D, 0, "trap_dec");
`else
        step(0, BAD, S_F, 1, "nop_f");
        step(0, BAD, S_D, 0, "nop_dec");
        step(0, RT,  S_F, 1, "nop_f2");
`endif

        // async reset mid-MEMREAD, MEM_LAT=3
        start(2, 1'b0);
        step(2, LW, S_F,  0, "ar_f0");
        step(2, LW, S_F,  0, "ar_f1");
        step(2, LW, S_F,  0, "ar_f2");
        step(2, LW, S_F,  1, "ar_f3");
        step(2, LW, S_D,  0, "ar_dec");
        step(2, LW, S_MA, 0, "ar_adr");
        step(2, LW, S_MR, 0, "ar_rd0");
        chk_now(2, ref_out(S_MR, 1'b0), "ar_rd1");
        #1;
        rst_n[2] = 1'b0;
        #1;
        chk_now(2, ref_out(S_F, 1'b0), "ar_async");
        @(posedge clk);
        #1;
        rst_n[2] = 1'b1;
        step(2, LW, S_F, 0, "ar2_f0");
        step(2, LW, S_F, 0, "ar2_f1");
        step(2, LW, S_F, 0, "ar2_f2");
        step(2, LW, S_F, 1, "ar2_f3");
        step(2, LW, S_D, 0, "ar2_dec");

        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0",
                     q0.size() + q1.size() + q2.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
